// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular FIFO; frames go out back-to-back while data is queued.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 4167,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [7:0]       head_byte;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             baud_last;
`ifdef UART_TX_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  assign tx_ready   = (level_reg != LVL_FULL);
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (level_reg == '0);
  assign head_byte  = fifo_mem[rd_ptr_reg];
  assign baud_last  = (baud_cnt_reg == BAUD_LAST);

  // Storage carries no reset so it can map onto plain memory; the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_last ? '0 : baud_cnt_reg + CNT_W'(1);
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    pop           = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        tx_next       = 1'b1;
        baud_cnt_next = '0;
        pop           = !fifo_empty;
      end
      START: begin
        if (baud_last) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_reg;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          pop        = !fifo_empty;
          state_next = IDLE;
          tx_next    = 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        baud_cnt_next = '0;
        tx_next       = 1'b1;
      end
    endcase

    // A pop always launches a start bit on the next cycle, from IDLE or straight out of STOP.
    if (pop) begin
      state_next    = START;
      baud_cnt_next = '0;
      shift_next    = head_byte;
      tx_next       = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next   = ^head_byte;
`endif
    end
  end

  assign tx         = tx_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;
  assign fifo_level = level_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes queue up as expectations, an independent
// serial decoder pops and compares each frame it recovers from the tx line.
module tb_uart_tx_fifo;

  localparam int D     = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  uart_tx_fifo #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         rst_gen = 0;
  int         frames_done = 0;
  int         max_level = 0;
  bit         stalled = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Serial decoder: samples each bit at its centre, timed from the first low cycle of the start bit.
  initial begin : monitor
    int         gen;
    int         s;
    logic [7:0] b;
    logic       st_bit;
    logic       sp_bit;
    logic       par_bit;
    logic [7:0] want;
    forever begin
      @(negedge clock);
      if (resetb && tx === 1'b0) begin
        gen = rst_gen;
        s   = cyc;
        par_bit = 1'b0;
        repeat (D / 2) @(negedge clock);
        st_bit = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (D) @(negedge clock);
          b[k] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (D) @(negedge clock);
        par_bit = tx;
`endif
        repeat (D) @(negedge clock);
        sp_bit = tx;
        repeat (D - D / 2 - 1) @(negedge clock);
        if (gen == rst_gen) begin
          start_q.push_back(s);
          frames_done++;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
          end else begin
            want = exp_q.pop_front();
            $display("frame %0d start=%0d data=0x%02h expected=0x%02h", frames_done, s, b, want);
            check("frame_data", {24'h0, b}, {24'h0, want});
            check("start_bit", {31'h0, st_bit}, 32'h0);
            check("stop_bit", {31'h0, sp_bit}, 32'h1);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", {31'h0, par_bit}, {31'h0, ^want});
`endif
          end
        end
      end
    end
  end

  // Every cycle out of reset: ready mirrors "not full" and the level never exceeds the depth.
  initial begin : invariants
    forever begin
      @(negedge clock);
      if (resetb) begin
        check("ready_vs_level", {31'h0, tx_ready}, {31'h0, (fifo_level != 3'(DEPTH))});
        if (int'(fifo_level) > DEPTH) check("level_bound", {29'h0, fifo_level}, DEPTH);
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge right after the accepting edge (cyc == acc).
  task automatic send(input logic [7:0] b, output int acc);
    int t;
    tx_data  = b;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (t > 0) stalled = 1'b1;
    if (!tx_ready) begin
      check("accept_timeout", 32'h0, 32'h1);
      tx_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
      exp_q.push_back(b);
      @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin
      @(negedge clock);
      t++;
    end
    check("drain_timeout", {31'h0, (t < 5000)}, 32'h1);
    repeat (D) @(negedge clock);
  endtask

  initial begin : stimulus
    int acc;
    int n0;
    int fd;
    int lows;
    int gap;
    int a3c;

    resetb = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_ready", {31'h0, tx_ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_level", {29'h0, fifo_level}, 32'h0);
    resetb = 1'b1;
    repeat (2) @(negedge clock);

    // Single byte: latency, pop timing and frame length from the tx fall to busy dropping.
    send(8'hA5, acc);
    tx_valid = 1'b0;
    check("level_after_push", {29'h0, fifo_level}, 32'h1);
    check("tx_before_pop", {31'h0, tx}, 32'h1);
    @(negedge clock);
    check("tx_fall_latency", {31'h0, tx}, 32'h0);
    check("level_after_pop", {29'h0, fifo_level}, 32'h0);
    repeat (NBITS * D - 1) @(negedge clock);
    check("busy_last_cycle", {31'h0, busy}, 32'h1);
    @(negedge clock);
    check("busy_fall", {31'h0, busy}, 32'h0);
    check("tx_idle_after", {31'h0, tx}, 32'h1);
    wait_idle();
    check("start_cycle", start_q[$], acc + 1);

    // Burst with valid held: fills the FIFO, stalls the producer, frames must abut.
    stalled   = 1'b0;
    max_level = 0;
    n0 = start_q.size();
    for (int i = 0; i < 6; i++) send(8'h41 + 8'(i), acc);
    tx_valid = 1'b0;
    wait_idle();
    check("burst_max_level", max_level, DEPTH);
    check("burst_stalled", {31'h0, stalled}, 32'h1);
    check("burst_frames", start_q.size() - n0, 6);
    for (int i = 1; i < 6; i++) begin
      check("burst_contiguous", start_q[n0 + i] - start_q[n0 + i - 1], NBITS * D);
    end

    // Parity-relevant bytes, then a saturated stream that wraps the pointers several times.
    send(8'h07, acc);
    send(8'h03, acc);
    for (int i = 0; i < 12; i++) send(8'($urandom_range(0, 255)), acc);
    tx_valid = 1'b0;
    wait_idle();

    // Random bytes with random idle gaps.
    for (int i = 0; i < 16; i++) begin
      gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 50)) : 0;
      tx_valid = 1'b0;
      repeat (gap) @(negedge clock);
      send(8'($urandom_range(0, 255)), acc);
    end
    tx_valid = 1'b0;
    wait_idle();

    // Reset during data bit 3 of 0x3C with two bytes queued behind it.
    send(8'h3C, a3c);
    send(8'h11, acc);
    send(8'h22, acc);
    tx_valid = 1'b0;
    while (cyc < a3c + 1 + 4 * D + 1) @(negedge clock);
    resetb = 1'b0;
    exp_q.delete();
    rst_gen++;
    #1;
    check("midframe_rst_tx", {31'h0, tx}, 32'h1);
    check("midframe_rst_level", {29'h0, fifo_level}, 32'h0);
    check("midframe_rst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    fd   = frames_done;
    lows = 0;
    for (int i = 0; i < 12 * D; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("no_frames_after_rst", lows, 0);
    check("frames_after_rst", frames_done, fd);

    send(8'h55, acc);
    tx_valid = 1'b0;
    wait_idle();
    check("post_rst_frame", frames_done, fd + 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
